// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    // Wide enough to hold RD_LAT_MAX-1.
    localparam int LAT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the arbiter bundled as one port.
// slave: the arbiter side. master: requesters plus memory model side.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [MASK_W-1:0] p0_mask;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [MASK_W-1:0] p1_mask;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_out;
    logic [MASK_W-1:0] mem_wr_mask;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_data_in;

    logic              busy;
    logic              owner;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_mask,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_mask,
        input  mem_data_in,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output mem_addr, mem_data_out, mem_wr_mask, mem_rd, mem_wr,
        output busy, owner
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_mask,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_mask,
        output mem_data_in,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  mem_addr, mem_data_out, mem_wr_mask, mem_rd, mem_wr,
        input  busy, owner
    );

endinterface

// File: rtl/arb_pick.sv
// Two-way request picker.
// MEM_ARBITER_RR_EN defined: a tie goes to the port not granted last.
// Otherwise port 0 always wins a tie and the last-grant input is ignored.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    assign valid = |req;

`ifdef MEM_ARBITER_RR_EN
    // Alternate on a tie, otherwise hand the grant to whichever port asks.
    always_comb begin
        winner = PORT0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = PORT1;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    // Port 1 only wins when port 0 is not asking.
    always_comb begin
        winner = PORT0;
        if (!req[0] && req[1]) begin
            winner = PORT1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants one requester at a time, issues a single
// read or write strobe, waits RD_LAT cycles for read data and acks the owner.
// Optional macro MEM_ARBITER_RR_EN selects round-robin tie breaking.
//
// state    | meaning
// ST_IDLE  | no transaction; arbitrate on any request
// ST_ISSUE | mem_rd or mem_wr strobe high for this one cycle
// ST_WAIT  | read issued; counting down to the data-valid edge
// ST_ACK   | one-cycle ack to the owner; requests ignored
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
)
(
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.slave  bus
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_range
        $error("mem_arbiter: RD_LAT must be within 1..4");
    end

    // Loaded on ISSUE->WAIT; the capture edge is where it reads zero.
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    state_t            state;
    logic [LAT_W-1:0]  lat_cnt;
    logic              is_wr;

    logic              pick_winner;
    logic              pick_valid;
    logic              last_grant;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_mask;

    arb_pick u_pick (
        .req    ({bus.p1_req, bus.p0_req}),
        .last   (last_grant),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

`ifdef MEM_ARBITER_RR_EN
    // Remember the latest winner so the next tie goes the other way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= PORT1;
        end else if (state == ST_IDLE && pick_valid) begin
            last_grant <= pick_winner;
        end
    end
`else
    assign last_grant = PORT1;
`endif

    // Route the winning requester's fields toward the memory registers.
    always_comb begin
        if (pick_winner == PORT1) begin
            sel_we    = bus.p1_we;
            sel_addr  = bus.p1_addr;
            sel_wdata = bus.p1_wdata;
            sel_mask  = bus.p1_mask;
        end else begin
            sel_we    = bus.p0_we;
            sel_addr  = bus.p0_addr;
            sel_wdata = bus.p0_wdata;
            sel_mask  = bus.p0_mask;
        end
    end

    // Transaction sequencer; every output is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            lat_cnt          <= '0;
            is_wr            <= 1'b0;
            bus.owner        <= PORT0;
            bus.busy         <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_data_out <= '0;
            bus.mem_wr_mask  <= '0;
            bus.mem_rd       <= 1'b0;
            bus.mem_wr       <= 1'b0;
            bus.p0_ack       <= 1'b0;
            bus.p1_ack       <= 1'b0;
            bus.p0_rdata     <= '0;
            bus.p1_rdata     <= '0;
        end else begin
            bus.mem_rd <= 1'b0;
            bus.mem_wr <= 1'b0;
            bus.p0_ack <= 1'b0;
            bus.p1_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        bus.owner        <= pick_winner;
                        bus.busy         <= 1'b1;
                        bus.mem_addr     <= sel_addr;
                        bus.mem_data_out <= sel_wdata;
                        bus.mem_wr_mask  <= sel_we ? sel_mask : '0;
                        bus.mem_wr       <= sel_we;
                        bus.mem_rd       <= !sel_we;
                        is_wr            <= sel_we;
                        state            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (is_wr) begin
                        bus.p0_ack <= (bus.owner == PORT0);
                        bus.p1_ack <= (bus.owner == PORT1);
                        state      <= ST_ACK;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == '0) begin
                        if (bus.owner == PORT1) begin
                            bus.p1_rdata <= bus.mem_data_in;
                        end else begin
                            bus.p0_rdata <= bus.mem_data_in;
                        end
                        bus.p0_ack <= (bus.owner == PORT0);
                        bus.p1_ack <= (bus.owner == PORT1);
                        state      <= ST_ACK;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers push expected
// transactions per port, a negedge monitor checks strobes, acks, latency,
// arbitration order and read data against a word-level memory model.
module tb_mem_arbiter;

    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 400;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_arbiter_if bus();

    mem_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic        req    [2];
    logic        r_we   [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata[2];
    logic [3:0]  r_mask [2];
    logic [31:0] mem_din;

    assign bus.p0_req      = req[0];
    assign bus.p0_we       = r_we[0];
    assign bus.p0_addr     = r_addr[0];
    assign bus.p0_wdata    = r_wdata[0];
    assign bus.p0_mask     = r_mask[0];
    assign bus.p1_req      = req[1];
    assign bus.p1_we       = r_we[1];
    assign bus.p1_addr     = r_addr[1];
    assign bus.p1_wdata    = r_wdata[1];
    assign bus.p1_mask     = r_mask[1];
    assign bus.mem_data_in = mem_din;

    int          checks = 0;
    int          errors = 0;

    txn_t        exp_q[2][$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] dev_mem[logic [31:0]];

    int unsigned cyc = 0;
    logic [1:0]  req_snap = 2'b00;
    logic        model_last = 1'b1;
    logic        active[2];
    int unsigned strobe_cyc[2];
    int unsigned last_ack_cyc[2];
    logic [31:0] hold_rd[2];
    logic        gap_chk = 1'b0;
    logic        rd_pending = 1'b0;
    logic [31:0] rd_addr;
    int unsigned rd_cyc;
    int unsigned grant_log[$];
    int unsigned strobe_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    // Port 0 owns 0x000-0x1FC, port 1 owns 0x200-0x3FC, so per-port order fixes the data.
    function automatic logic [31:0] rand_addr(input int p);
        return 32'(p * 'h200 + 4 * $urandom_range(0, 127));
    endfunction

    function automatic logic ack_of(input int p);
        return (p == 0) ? bus.p0_ack : bus.p1_ack;
    endfunction

    // Reference arbitration: who should win given the requests pending at the grant edge.
    function automatic logic pick_ref(input logic [1:0] pend, input logic last);
        if (pend == 2'b11) begin
`ifdef MEM_ARBITER_RR_EN
            return ~last;
`else
            return 1'b0;
`endif
        end
        return pend[1];
    endfunction

    function automatic int unsigned exp_grant(input int i);
`ifdef MEM_ARBITER_RR_EN
        return i % 2;
`else
        return (i < 4) ? 0 : 1;
`endif
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        req_snap <= {req[1], req[0]};
    end

    always @(negedge clk) begin : monitor
        logic win;
        txn_t t;
        if (reset) begin
            model_last = 1'b1;
            active[0]  = 1'b0;
            active[1]  = 1'b0;
            hold_rd[0] = '0;
            hold_rd[1] = '0;
            gap_chk    = 1'b0;
            rd_pending = 1'b0;
            mem_din    = $urandom;
        end else begin
            if (rd_pending && cyc == rd_cyc + RD_LAT) begin
                mem_din    = dev_read(rd_addr);
                rd_pending = 1'b0;
            end else begin
                mem_din = $urandom;
            end

            if (gap_chk) begin
                chk("idle_gap_busy", bus.busy, 0);
                chk("idle_gap_strobe", {bus.mem_rd, bus.mem_wr}, 0);
                gap_chk = 1'b0;
            end

            if (bus.mem_rd || bus.mem_wr) begin
                chk("one_strobe", bus.mem_rd & bus.mem_wr, 0);
                chk("busy_in_issue", bus.busy, 1);
                chk("strobe_has_req", req_snap != 2'b00, 1);
                win = pick_ref(req_snap, model_last);
                model_last = win;
                grant_log.push_back(int'(win));
                strobe_log.push_back(cyc);
                chk("owner", bus.owner, win);
                chk("strobe_expected", exp_q[win].size() > 0, 1);
                if (exp_q[win].size() > 0) begin
                    t = exp_q[win][0];
                    chk("strobe_dir", bus.mem_wr, t.we);
                    chk("mem_addr", bus.mem_addr, t.addr);
                    chk("mem_wr_mask", bus.mem_wr_mask, t.we ? t.mask : 4'h0);
                    if (t.we) chk("mem_data_out", bus.mem_data_out, t.wdata);
                end
                strobe_cyc[win] = cyc;
                active[win]     = 1'b1;
                if (bus.mem_wr) begin
                    dev_mem[bus.mem_addr] = merge(dev_read(bus.mem_addr), bus.mem_data_out,
                                                  bus.mem_wr_mask);
                end else begin
                    rd_pending = 1'b1;
                    rd_addr    = bus.mem_addr;
                    rd_cyc     = cyc;
                end
            end

            if (bus.p0_ack || bus.p1_ack) begin
                chk("single_ack", bus.p0_ack & bus.p1_ack, 0);
                chk("busy_in_ack", bus.busy, 1);
                gap_chk = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    if (ack_of(p)) begin
                        chk("ack_expected", active[p] && exp_q[p].size() > 0, 1);
                        if (active[p] && exp_q[p].size() > 0) begin
                            t = exp_q[p].pop_front();
                            chk("ack_latency", cyc - strobe_cyc[p], t.we ? 1 : 1 + RD_LAT);
                            if (!t.we) hold_rd[p] = t.rdata;
                            last_ack_cyc[p] = cyc;
                            active[p]       = 1'b0;
                        end
                    end
                end
                chk("p0_rdata", bus.p0_rdata, hold_rd[0]);
                chk("p1_rdata", bus.p1_rdata, hold_rd[1]);
            end
        end
    end

    // One transaction on port p: predict, request, wait for the ack, release.
    task automatic do_txn(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
        txn_t t;
        logic got;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.mask  = mask;
        t.rdata = ref_read(addr);
        if (we) ref_mem[addr] = merge(ref_read(addr), wdata, mask);
        exp_q[p].push_back(t);
        r_we[p]    = we;
        r_addr[p]  = addr;
        r_wdata[p] = wdata;
        r_mask[p]  = mask;
        req[p]     = 1'b1;
        got = 1'b0;
        for (int n = 0; n < TIMEOUT && !got; n++) begin
            @(negedge clk);
            got = ack_of(p);
        end
        req[p] = 1'b0;
        chk("ack_timeout", got, 1);
        @(negedge clk);
    endtask

    task automatic wait_rd_strobe(output logic seen);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = bus.mem_rd;
        end
        chk("rd_strobe_seen", seen, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_data_out"}, bus.mem_data_out, 0);
        chk({tag, "_mem_wr_mask"}, bus.mem_wr_mask, 0);
        chk({tag, "_strobes"}, {bus.mem_rd, bus.mem_wr}, 0);
        chk({tag, "_acks"}, {bus.p0_ack, bus.p1_ack}, 0);
        chk({tag, "_p0_rdata"}, bus.p0_rdata, 0);
        chk({tag, "_p1_rdata"}, bus.p1_rdata, 0);
        chk({tag, "_busy_owner"}, {bus.busy, bus.owner}, 0);
    endtask

    task automatic rand_loop(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_txn(p, 1'($urandom_range(0, 1)), rand_addr(p), $urandom, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic        seen;
        logic [31:0] a;
        txn_t        t;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wdata[p] = '0; r_mask[p] = '0;
        end
        mem_din = '0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single write from port 0.
        do_txn(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        chk("wr_landed", dev_read(32'h100), 32'hDEADBEEF);

        // Single read from port 1 with known memory contents.
        dev_mem[32'h200] = 32'h12345678;
        ref_mem[32'h200] = 32'h12345678;
        do_txn(1, 1'b0, 32'h200, 32'h0, 4'hF);
        chk("rd_value", bus.p1_rdata, 32'h12345678);

        // Both ports requesting continuously.
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) do_txn(0, 1'b1, rand_addr(0), $urandom, 4'hF);
            end
            begin
                for (int i = 0; i < 4; i++) do_txn(1, 1'b1, rand_addr(1), $urandom, 4'hF);
            end
        join
        chk("grant_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            chk("grant_order", grant_log[i], exp_grant(i));
        end

        // Port 1 arrives while port 0 waits for read data.
        fork
            do_txn(0, 1'b0, rand_addr(0), 32'h0, 4'h0);
            begin
                logic s;
                wait_rd_strobe(s);
                @(negedge clk);
                do_txn(1, 1'b1, rand_addr(1), $urandom, 4'h3);
            end
        join
        chk("p1_after_p0_ack", strobe_cyc[1] - last_ack_cyc[0], 2);

        // Reset while a read sits in WAIT, then re-issue it.
        a       = rand_addr(0);
        t.we    = 1'b0;
        t.addr  = a;
        t.wdata = '0;
        t.mask  = 4'hF;
        t.rdata = ref_read(a);
        exp_q[0].push_back(t);
        r_we[0] = 1'b0; r_addr[0] = a; r_mask[0] = 4'hF;
        req[0]  = 1'b1;
        wait_rd_strobe(seen);
        @(negedge clk);
        chk("busy_in_wait", bus.busy, 1);
        reset  = 1'b1;
        req[0] = 1'b0;
        #1;
        check_zero("rst_wait");
        repeat (3) begin
            @(negedge clk);
            chk("no_ack_in_reset", {bus.p0_ack, bus.p1_ack}, 0);
        end
        exp_q[0].delete();
        exp_q[1].delete();
        reset = 1'b0;
        @(negedge clk);
        do_txn(0, 1'b0, a, 32'h0, 4'hF);

        // Back-to-back writes from port 0.
        strobe_log.delete();
        for (int i = 0; i < 4; i++) do_txn(0, 1'b1, rand_addr(0), $urandom, 4'($urandom_range(0, 15)));
        chk("b2b_count", strobe_log.size(), 4);
        for (int i = 1; i < strobe_log.size(); i++) begin
            chk("wr_spacing", strobe_log[i] - strobe_log[i-1], 3);
        end

        // Random traffic on both ports.
        fork
            rand_loop(0, 30);
            rand_loop(1, 30);
        join

        repeat (5) @(negedge clk);
        chk("queue_drain", exp_q[0].size() + exp_q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
